// File: rtl/ecc_apb_sequencer.sv
// APB requester for the ECC_ENC_DEC slave: takes one job, writes DATA_IN, CODEWORD_WIDTH,
// NOISE and CTRL, then waits for operation_done (or a timeout) and returns one response.
module ecc_apb_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int ADDR_CTRL       = 0,
  parameter int ADDR_DATA_IN    = 4,
  parameter int ADDR_CW_WIDTH   = 8,
  parameter int ADDR_NOISE      = 12,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_mode,
  input  logic [1:0]                 job_cw_width,
  input  logic [AMBA_WORD-1:0]       job_data,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic [1:0]                 rsp_status
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [1:0]                   mode_q, mode_d;
  logic [1:0]                   cw_q, cw_d;
  logic [AMBA_WORD-1:0]         noise_q, noise_d;
  logic [AMBA_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]         pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic [1:0]                   rsp_err_q, rsp_err_d;
  logic [1:0]                   rsp_status_q, rsp_status_d;

  // Bus control is decoded straight from the state so reset drops PSEL/PENABLE at once.
  assign PSEL       = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE    = (state_q == ACCESS);
  assign PWRITE     = PSEL;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign job_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_errors = rsp_err_q;
  assign rsp_status = rsp_status_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    cw_d         = cw_q;
    noise_d      = noise_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          mode_d  = job_mode;
          cw_d    = job_cw_width;
          noise_d = job_noise;
          idx_d   = 2'd0;
          cnt_d   = '0;
          if (job_mode == 2'd3) begin
            state_d      = RESP;
            rsp_status_d = 2'b10;
            rsp_data_d   = '0;
            rsp_err_d    = 2'd0;
          end else begin
            // DATA_IN is the only write taken straight from the job inputs.
            state_d  = SETUP;
            paddr_d  = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);
            pwdata_d = job_data;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (idx_q == 2'd3) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + 2'd1;
          case (idx_q)
            2'd0: begin
              paddr_d  = AMBA_ADDR_WIDTH'(ADDR_CW_WIDTH);
              pwdata_d = AMBA_WORD'(cw_q);
            end
            2'd1: begin
              paddr_d  = AMBA_ADDR_WIDTH'(ADDR_NOISE);
              pwdata_d = noise_q;
            end
            default: begin
              paddr_d  = AMBA_ADDR_WIDTH'(ADDR_CTRL);
              pwdata_d = AMBA_WORD'(mode_q);
            end
          endcase
        end
      end
      WAIT_DONE: begin
        // A done strobe on the final counted cycle still wins over the timeout.
        if (operation_done) begin
          state_d      = RESP;
          rsp_data_d   = data_out;
          rsp_err_d    = num_of_errors;
          rsp_status_d = 2'b00;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          rsp_data_d   = '0;
          rsp_err_d    = 2'd0;
          rsp_status_d = 2'b01;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      mode_q       <= 2'd0;
      cw_q         <= 2'd0;
      noise_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 2'd0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      cw_q         <= cw_d;
      noise_q      <= noise_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer: expected APB writes and responses are queued when a
// job is driven and compared as the sequencer produces them.
module tb_ecc_apb_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_mode;
  logic [1:0]  job_cw_width;
  logic [31:0] job_data;
  logic [31:0] job_noise;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_errors;
  logic [1:0]  rsp_status;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } apb_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    logic [1:0]  status;
  } rsp_t;

  apb_t exp_apb[$];
  rsp_t exp_rsp[$];

  int n_cmp = 0;
  int n_err = 0;

  ecc_apb_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_mode       (job_mode),
    .job_cw_width   (job_cw_width),
    .job_data       (job_data),
    .job_noise      (job_noise),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_errors     (rsp_errors),
    .rsp_status     (rsp_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one job and follows it through APB writes, the wait and the response handshake.
  // done_after < 0 means operation_done is never raised; setup_glitch pulses done in SETUP.
  task automatic run_job(input logic [1:0] mode, input logic [1:0] cw, input logic [31:0] data,
                         input logic [31:0] noise, input int done_after, input logic [31:0] dout,
                         input logic [1:0] derr, input int hold, input bit setup_glitch);
    rsp_t r;
    apb_t a;
    chk("idle_job_ready", job_ready, 1);
    job_valid    = 1'b1;
    job_mode     = mode;
    job_cw_width = cw;
    job_data     = data;
    job_noise    = noise;
    if (mode == 2'd3) begin
      r.data = 0; r.err = 0; r.status = 2'b10;
    end else begin
      exp_apb.push_back('{32'd4,  data});
      exp_apb.push_back('{32'd8,  {30'd0, cw}});
      exp_apb.push_back('{32'd12, noise});
      exp_apb.push_back('{32'd0,  {30'd0, mode}});
      if (done_after >= 0 && done_after < TIMEOUT) begin
        r.data = dout; r.err = derr; r.status = 2'b00;
      end else begin
        r.data = 0; r.err = 0; r.status = 2'b01;
      end
    end
    exp_rsp.push_back(r);
    next_cycle();
    job_valid    = 1'b0;
    job_mode     = ~mode;
    job_cw_width = ~cw;
    job_data     = $urandom;
    job_noise    = $urandom;
    if (mode != 2'd3) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 0 && setup_glitch) begin
          operation_done = 1'b1;
          data_out       = 32'hFFFF_FFFF;
          num_of_errors  = 2'd3;
        end else begin
          operation_done = 1'b0;
        end
        chk("apb_queue_nonempty", 32'(exp_apb.size() > 0), 1);
        if (exp_apb.size() > 0) begin
          a = exp_apb[0];
          chk("apb_psel", PSEL, 1);
          chk("apb_penable", PENABLE, 32'(i % 2));
          chk("apb_pwrite", PWRITE, 1);
          chk("apb_paddr", PADDR, a.addr);
          chk("apb_pwdata", PWDATA, a.data);
          if (i % 2 == 1) void'(exp_apb.pop_front());
        end
        chk("apb_rsp_valid", rsp_valid, 0);
        next_cycle();
      end
      operation_done = 1'b0;
      data_out       = 32'h5555_AAAA;
      num_of_errors  = 2'd2;
      for (int w = 0; w < TIMEOUT; w++) begin
        chk("wait_psel", PSEL, 0);
        chk("wait_penable", PENABLE, 0);
        chk("wait_rsp_valid", rsp_valid, 0);
        chk("wait_paddr_hold", PADDR, 0);
        chk("wait_pwdata_hold", PWDATA, {30'd0, mode});
        if (w == done_after) begin
          operation_done = 1'b1;
          data_out       = dout;
          num_of_errors  = derr;
          next_cycle();
          operation_done = 1'b0;
          data_out       = $urandom;
          num_of_errors  = 2'd3;
          break;
        end
        next_cycle();
      end
    end
    chk("rsp_queue_nonempty", 32'(exp_rsp.size() > 0), 1);
    if (exp_rsp.size() > 0) r = exp_rsp.pop_front();
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_job_ready", job_ready, 0);
      chk("hold_psel", PSEL, 0);
      chk("hold_rsp_data", rsp_data, r.data);
      chk("hold_rsp_status", rsp_status, {30'd0, r.status});
      next_cycle();
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_psel", PSEL, 0);
    chk("rsp_data", rsp_data, r.data);
    chk("rsp_errors", rsp_errors, {30'd0, r.err});
    chk("rsp_status", rsp_status, {30'd0, r.status});
    chk("rsp_job_ready", job_ready, 0);
    next_cycle();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_job_ready", job_ready, 1);
  endtask

  initial begin
    rst            = 1'b0;
    job_valid      = 1'b0;
    job_mode       = 2'd0;
    job_cw_width   = 2'd0;
    job_data       = 32'd0;
    job_noise      = 32'd0;
    operation_done = 1'b0;
    data_out       = 32'd0;
    num_of_errors  = 2'd0;
    rsp_ready      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_pwrite", PWRITE, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_errors", rsp_errors, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_job_ready", job_ready, 1);
    #2 rst = 1'b1;
    next_cycle();

    $display("[TB] encode, done at earliest cycle");
    run_job(2'd0, 2'd0, 32'h0000_00A5, 32'd0, 0, 32'h0000_03A5, 2'd0, 0, 1'b0);

    $display("[TB] decode, done after 20 wait cycles");
    run_job(2'd1, 2'd2, 32'h1234_5678, 32'h0000_0004, 20, 32'hDEAD_BEEF, 2'd1, 0, 1'b0);

    $display("[TB] full channel, timeout");
    run_job(2'd2, 2'd3, 32'hCAFE_F00D, 32'h8000_0001, -1, 32'd0, 2'd0, 0, 1'b0);

    $display("[TB] illegal mode, response held");
    run_job(2'd3, 2'd1, 32'h0BAD_0BAD, 32'h1111_1111, -1, 32'd0, 2'd0, 5, 1'b0);

    $display("[TB] reset during third access");
    job_valid    = 1'b1;
    job_mode     = 2'd0;
    job_cw_width = 2'd1;
    job_data     = 32'h0000_0077;
    job_noise    = 32'h0000_0300;
    next_cycle();
    job_valid = 1'b0;
    repeat (5) next_cycle();
    chk("abort_in_access", PENABLE, 1);
    chk("abort_paddr_noise", PADDR, 12);
    #2 rst = 1'b0;
    #1;
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_job_ready", job_ready, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk("abort_hold_psel", PSEL, 0);
      chk("abort_hold_rsp_valid", rsp_valid, 0);
    end
    #2 rst = 1'b1;
    next_cycle();
    chk("after_abort_rsp_valid", rsp_valid, 0);
    run_job(2'd0, 2'd0, 32'h0000_00A5, 32'd0, 0, 32'h0000_03A5, 2'd0, 0, 1'b0);

    $display("[TB] done pulse during setup is ignored");
    run_job(2'd0, 2'd1, 32'h0F0F_0F0F, 32'h0000_0010, -1, 32'd0, 2'd0, 0, 1'b1);

    $display("[TB] done on the last counted wait cycle");
    run_job(2'd1, 2'd0, 32'h2468_ACE0, 32'h0000_0002, TIMEOUT - 1, 32'h1357_9BDF, 2'd2, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
